// File: rtl/scan_ctrl_pkg.sv
// Shared types and defaults for the scan chain controller.
package scan_ctrl_pkg;

    localparam int CHAIN_LEN_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        UNLOAD,
        RESP
    } scan_state_t;

endpackage

// File: rtl/scan_shreg.sv
// Parallel-load shift register, MSB-first serial out, serial in at the LSB.
module scan_shreg
    import scan_ctrl_pkg::*;
#(
    parameter int W = CHAIN_LEN_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_data,
    input  logic         i_shift,
    input  logic         i_si,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Load wins over shift so an accepted pattern is never corrupted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_data;
        end else if (i_shift) begin
            r_q <= {r_q[W-2:0], i_si};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/scan_ctrl.sv
// Scan test controller: shifts a pattern into a chain, pulses one capture
// cycle, shifts the response out and offers it on a valid/ready port.
module scan_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT
) (
    input  logic                 CP,
    input  logic                 RST,
    input  logic                 PAT_VALID,
    output logic                 PAT_READY,
    input  logic [CHAIN_LEN-1:0] PAT_DATA,
    output logic                 TE,
    output logic                 TI,
    input  logic                 SO,
    output logic                 RSP_VALID,
    input  logic                 RSP_READY,
    output logic [CHAIN_LEN-1:0] RSP_DATA,
    output logic                 BUSY,
    output scan_state_t          o_dbg_state,
    output logic [CHAIN_LEN-1:0] o_dbg_stim
);

    // Handshakes: a transfer happens on a rising CP edge where valid and
    // ready are both high; valid, once raised by the producer, is held.
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    scan_state_t          r_state;
    scan_state_t          w_next_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_te;
    logic                 r_pat_ready;
    logic                 r_rsp_valid;
    logic                 r_busy;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_stim_shift;
    logic                 w_rsp_shift;
    logic [CHAIN_LEN-1:0] w_stim_q;

    assign w_accept     = (r_state == IDLE) && r_pat_ready && PAT_VALID;
    assign w_last       = (r_cnt == CNT_LAST);
    assign w_stim_shift = (r_state == LOAD);
    assign w_rsp_shift  = (r_state == UNLOAD);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next_state = LOAD;
            LOAD:    if (w_last)    w_next_state = CAPTURE;
            CAPTURE:                w_next_state = UNLOAD;
            UNLOAD:  if (w_last)    w_next_state = RESP;
            RESP:    if (RSP_READY) w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every one is a flop.
    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_te        <= 1'b0;
            r_pat_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (w_stim_shift || w_rsp_shift) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_te        <= (w_next_state == LOAD) || (w_next_state == UNLOAD);
            r_pat_ready <= (w_next_state == IDLE);
            r_rsp_valid <= (w_next_state == RESP);
            r_busy      <= (w_next_state != IDLE);
        end
    end

    // Zeros shift in behind the pattern, so TI falls to 0 once LOAD ends.
    scan_shreg #(.W(CHAIN_LEN)) u_stim (
        .i_clk       (CP),
        .i_rst       (RST),
        .i_load      (w_accept),
        .i_load_data (PAT_DATA),
        .i_shift     (w_stim_shift),
        .i_si        (1'b0),
        .o_q         (w_stim_q)
    );

    scan_shreg #(.W(CHAIN_LEN)) u_rsp (
        .i_clk       (CP),
        .i_rst       (RST),
        .i_load      (1'b0),
        .i_load_data ({CHAIN_LEN{1'b0}}),
        .i_shift     (w_rsp_shift),
        .i_si        (SO),
        .o_q         (RSP_DATA)
    );

    assign TE          = r_te;
    assign TI          = w_stim_q[CHAIN_LEN-1];
    assign PAT_READY   = r_pat_ready;
    assign RSP_VALID   = r_rsp_valid;
    assign BUSY        = r_busy;
    assign o_dbg_state = r_state;
    assign o_dbg_stim  = w_stim_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl: four-cell scan chain model, transaction-level
// reference, directed cases and randomized traffic with reset pulses.
module tb_scan_ctrl;
    import scan_ctrl_pkg::*;

    localparam int N  = 4;
    localparam int NS = 2;
    localparam int NL = 256;

    // ---------------- clock / reset ----------------
    logic CP  = 1'b0;
    logic RST = 1'b1;
    always #5 CP = ~CP;

    // ---------------- main DUT (CHAIN_LEN = 4) ----------------
    logic          pat_valid = 1'b0;
    logic          pat_ready;
    logic [N-1:0]  pat_data  = '0;
    logic          te, ti, so;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [N-1:0]  rsp_data;
    logic          busy;
    scan_state_t   dbg_state;
    logic [N-1:0]  dbg_stim;

    scan_ctrl #(.CHAIN_LEN(N)) u_dut (
        .CP(CP), .RST(RST), .PAT_VALID(pat_valid), .PAT_READY(pat_ready),
        .PAT_DATA(pat_data), .TE(te), .TI(ti), .SO(so), .RSP_VALID(rsp_valid),
        .RSP_READY(rsp_ready), .RSP_DATA(rsp_data), .BUSY(busy),
        .o_dbg_state(dbg_state), .o_dbg_stim(dbg_stim)
    );

    // ---------------- size corner DUTs (SO tied high) ----------------
    logic          pv_s = 1'b0, pr_s, te_s, ti_s, rv_s, busy_s;
    logic [NS-1:0] rd_s, stim_s;
    scan_state_t   st_s;
    logic          pv_l = 1'b0, pr_l, te_l, ti_l, rv_l, busy_l;
    logic [NL-1:0] rd_l, stim_l;
    scan_state_t   st_l;

    scan_ctrl #(.CHAIN_LEN(NS)) u_dut_s (
        .CP(CP), .RST(RST), .PAT_VALID(pv_s), .PAT_READY(pr_s),
        .PAT_DATA({NS{1'b0}}), .TE(te_s), .TI(ti_s), .SO(1'b1), .RSP_VALID(rv_s),
        .RSP_READY(1'b0), .RSP_DATA(rd_s), .BUSY(busy_s),
        .o_dbg_state(st_s), .o_dbg_stim(stim_s)
    );

    scan_ctrl #(.CHAIN_LEN(NL)) u_dut_l (
        .CP(CP), .RST(RST), .PAT_VALID(pv_l), .PAT_READY(pr_l),
        .PAT_DATA({NL{1'b0}}), .TE(te_l), .TI(ti_l), .SO(1'b1), .RSP_VALID(rv_l),
        .RSP_READY(1'b0), .RSP_DATA(rd_l), .BUSY(busy_l),
        .o_dbg_state(st_l), .o_dbg_stim(stim_l)
    );

    // ---------------- scan chain: chain[0] = head, chain[N-1] = tail ----------------
    // With bypass set the chain skips the capture edge, so the loaded pattern
    // comes back out unchanged.
    logic [N-1:0] chain  = '0;
    logic [N-1:0] d_func = '0;
    logic         bypass = 1'b0;
    assign so = chain[N-1];

    always @(posedge CP) begin
        if (te)                   chain <= {chain[N-2:0], ti};
        else if (!(bypass && busy)) chain <= d_func;
    end

    // ---------------- reference model ----------------
    // m_mode: 0 = just reset, 1 = idle, 2 = transaction running.
    // m_t counts edges since acceptance: 0..N-1 load, N capture,
    // N+1..2N unload, 2N+1 response.
    int           m_mode = 0;
    int           m_t    = 0;
    logic [N-1:0] m_pat  = '0;
    logic [N-1:0] m_exp  = '0;
    logic [N-1:0] m_last = '0;

    always @(posedge CP or posedge RST) begin
        if (RST) begin
            m_mode <= 0;
            m_t    <= 0;
            m_last <= '0;
        end else begin
            case (m_mode)
                0: m_mode <= 1;
                1: if (pat_valid) begin
                    m_mode <= 2;
                    m_t    <= 0;
                    m_pat  <= pat_data;
                    m_exp  <= bypass ? pat_data : d_func;
                end
                default: begin
                    if (m_t < 2*N+1) m_t <= m_t + 1;
                    else if (rsp_ready) begin
                        m_mode <= 1;
                        m_last <= m_exp;
                    end
                end
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    logic [N-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge CP) begin : cmp
        int t;
        bit act, in_load, in_unload, in_resp;
        if (chk_en) begin
            act       = (m_mode == 2);
            t         = m_t;
            in_load   = act && (t < N);
            in_unload = act && (t > N) && (t <= 2*N);
            in_resp   = act && (t == 2*N+1);
            check("te", te, in_load || in_unload);
            check("ti", ti, in_load ? m_pat[N-1-t] : 1'b0);
            check("pat_ready", pat_ready, m_mode == 1);
            check("busy", busy, act);
            check("rsp_valid", rsp_valid, in_resp);
            if (!in_unload) check("rsp_data", rsp_data, in_resp ? m_exp : m_last);
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge of the first RSP_VALID cycle.
    task automatic run_tx(input logic [N-1:0] pat, input logic [N-1:0] d, input bit byp,
                          output int lat, output logic [N-1:0] ti_seq, output logic [4:0] te_pat);
        int guard;
        guard = 0;
        while (!pat_ready && guard < 50) begin
            @(negedge CP);
            guard++;
        end
        check("ready_wait", pat_ready, 1'b1);
        pat_data  = pat;
        d_func    = d;
        bypass    = byp;
        pat_valid = 1'b1;
        @(negedge CP);
        pat_valid = 1'b0;
        lat    = 0;
        ti_seq = '0;
        te_pat = '0;
        while (!rsp_valid && lat < 100) begin
            if (lat < N)  ti_seq = {ti_seq[N-2:0], ti};
            if (lat <= N) te_pat = {te_pat[3:0], te};
            @(negedge CP);
            lat++;
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(negedge CP);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat, got, idle_gap, cyc, lat_s, lat_l;
        bit           seen_busy, sent_b;
        logic [N-1:0] ti_seq;
        logic [4:0]   te_pat;

        #1 chk_en = 1'b1;
        check("rst_rsp_data", rsp_data, 4'b0000);
        check("rst_ready", pat_ready, 1'b0);
        check("rst_te", te, 1'b0);
        repeat (2) @(negedge CP);
        RST = 1'b0;
        @(posedge CP);
        #1 check("ready_after_rst", pat_ready, 1'b1);
        @(negedge CP);

        // Nominal transaction with functional capture of 1010.
        run_tx(4'b0110, 4'b1010, 1'b0, lat, ti_seq, te_pat);
        check("lat_nominal", lat, 9);
        check("ti_sequence", ti_seq, 4'b0110);
        check("te_pattern", te_pat, 5'b11110);
        check("rsp_nominal", rsp_data, 4'b1010);

        // Consumer stalls; offered patterns must be ignored.
        for (int i = 0; i < 10; i++) begin
            pat_valid = 1'b1;
            pat_data  = N'($urandom);
            @(negedge CP);
            check("stall_valid", rsp_valid, 1'b1);
            check("stall_data", rsp_data, 4'b1010);
            check("stall_ready", pat_ready, 1'b0);
        end
        pat_valid = 1'b0;
        release_rsp();
        check("idle_after_rsp", pat_ready, 1'b1);

        // Capture bypassed: response reproduces the pattern, proving shift order.
        run_tx(4'b1001, 4'b0000, 1'b1, lat, ti_seq, te_pat);
        check("rsp_bypass", rsp_data, 4'b1001);
        check("lat_bypass", lat, 9);
        release_rsp();

        // Reset in load cycle 2 aborts the transaction.
        pat_data  = 4'b1111;
        d_func    = 4'b0000;
        bypass    = 1'b0;
        pat_valid = 1'b1;
        @(negedge CP);
        pat_valid = 1'b0;
        repeat (2) @(negedge CP);
        #2 RST = 1'b1;
        #1;
        check("abort_te", te, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_rsp_data", rsp_data, 4'b0000);
        @(negedge CP);
        RST = 1'b0;
        @(negedge CP);
        run_tx(4'b1100, 4'b0101, 1'b0, lat, ti_seq, te_pat);
        check("lat_after_abort", lat, 9);
        check("ti_after_abort", ti_seq, 4'b1100);
        check("te_after_abort", te_pat, 5'b11110);
        check("rsp_after_abort", rsp_data, 4'b0101);
        release_rsp();

        // Back-to-back patterns with the consumer always ready.
        exp_q.delete();
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b1101);
        bypass    = 1'b1;
        d_func    = '0;
        rsp_ready = 1'b1;
        pat_data  = 4'b0011;
        pat_valid = 1'b1;
        got = 0; idle_gap = 0; cyc = 0; seen_busy = 1'b0; sent_b = 1'b0;
        while (got < 2 && cyc < 80) begin
            @(negedge CP);
            cyc++;
            if (busy) seen_busy = 1'b1;
            if (seen_busy && !busy) idle_gap++;
            if (busy && idle_gap > 0) pat_valid = 1'b0;
            if (busy && !sent_b) begin
                pat_data = 4'b1101;
                sent_b   = 1'b1;
            end
            if (rsp_valid) begin
                check("b2b_rsp", rsp_data, exp_q.pop_front());
                got++;
            end
        end
        check("b2b_count", got, 2);
        check("b2b_idle_gap", idle_gap, 1);
        pat_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge CP);

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 800; i++) begin
            @(negedge CP);
            if ($urandom_range(0, 149) == 0) begin
                #2 RST = 1'b1;
                @(negedge CP);
                RST = 1'b0;
            end
            pat_valid = $urandom_range(0, 1);
            pat_data  = N'($urandom);
            rsp_ready = ($urandom_range(0, 2) == 0);
            if (m_mode != 2) begin
                d_func = N'($urandom);
                bypass = $urandom_range(0, 1);
            end
        end
        pat_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge CP);

        // Chain length corners.
        check("small_ready", pr_s, 1'b1);
        check("large_ready", pr_l, 1'b1);
        pv_s = 1'b1;
        pv_l = 1'b1;
        @(negedge CP);
        pv_s = 1'b0;
        pv_l = 1'b0;
        lat_s = -1;
        lat_l = -1;
        for (int c = 0; c < 600; c++) begin
            if (rv_s && lat_s < 0) lat_s = c;
            if (rv_l && lat_l < 0) lat_l = c;
            if (lat_s >= 0 && lat_l >= 0) break;
            @(negedge CP);
        end
        check("lat_len2", lat_s, 5);
        check("lat_len256", lat_l, 513);
        check("rsp_len2", rd_s, 2'b11);
        check("rsp_len256_all_ones", rd_l == {NL{1'b1}}, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
